// File: rtl/typedefs_pkg.sv
// Shared Simon datapath types: colour codes, playback states and the LED bundle.
package typedefs_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ON    = 3'd3,
    OFF   = 3'd4,
    DONE  = 3'd5
  } play_state_t;

  typedef struct packed {
    logic yellow;
    logic blue;
    logic green;
    logic red;
  } leds_t;

endpackage

// File: rtl/sequence_player_if.sv
// Controller / memory / LED bundle seen by the sequence player.
interface sequence_player_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 2
);

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] last_index;
  logic                  speed;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  led_red;
  logic                  led_green;
  logic                  led_blue;
  logic                  led_yellow;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, last_index, speed, mem_data,
    input  mem_rd, mem_addr, led_red, led_green, led_blue, led_yellow, busy, done
  );

  modport slave (
    input  start, abort, last_index, speed, mem_data,
    output mem_rd, mem_addr, led_red, led_green, led_blue, led_yellow, busy, done
  );

endinterface

// File: rtl/color_decoder.sv
// Maps a colour code plus enable onto one-hot LED lines (all dark when disabled).
module color_decoder
  import typedefs_pkg::*;
(
  input  logic   en_i,
  input  color_t color_i,
  output leds_t  leds_o
);

  always_comb begin
    leds_o = '0;
    if (en_i) begin
      case (color_i)
        RED:     leds_o.red    = 1'b1;
        GREEN:   leds_o.green  = 1'b1;
        BLUE:    leds_o.blue   = 1'b1;
        YELLOW:  leds_o.yellow = 1'b1;
        default: leds_o        = '0;
      endcase
    end
  end

endmodule

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and increment enable.
module counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sequence_player.sv
// Simon playback scheduler: walks memory 0..last_index, flashing each colour
// for a speed-dependent on-time followed by a dark gap, then pulses done.
module sequence_player
  import typedefs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned FAST_ON    = 4,
  parameter int unsigned SLOW_ON    = 8,
  parameter int unsigned GAP        = 2
) (
  input  logic             clk,
  input  logic             rst,
  sequence_player_if.slave bus
);

  localparam int unsigned TICK_W = $clog2(SLOW_ON + GAP + 1);
  localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(FAST_ON - 1);
  localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(SLOW_ON - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP - 1);

  play_state_t           state_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [TICK_W-1:0]     on_last_q;
  logic [TICK_W-1:0]     tick_q;
  color_t                color_q;
  leds_t                 leds_q;
  logic                  mem_rd_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  start_ok_c;
  logic                  abort_c;
  logic                  tick_zero_c;
  logic                  last_item_c;
  logic                  addr_inc_c;
  logic                  lit_c;
  color_t                dec_color_c;
  leds_t                 leds_c;

  // Abort beats start in IDLE; the address counter only advances between items.
  always_comb begin
    start_ok_c  = (state_q == IDLE) && bus.start && !bus.abort;
    abort_c     = (state_q != IDLE) && bus.abort;
    tick_zero_c = (tick_q == '0);
    last_item_c = (addr_c == last_q);
    addr_inc_c  = (state_q == OFF) && tick_zero_c && !last_item_c && !bus.abort;
    lit_c       = !bus.abort &&
                  ((state_q == LOAD) || ((state_q == ON) && !tick_zero_c));
    dec_color_c = (state_q == LOAD) ? color_t'(bus.mem_data) : color_q;
  end

  counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_ok_c),
    .inc_i   (addr_inc_c),
    .count_o (addr_c)
  );

  // Decoded from the next-cycle colour so the LED register lines up with ON.
  color_decoder u_dec (
    .en_i    (lit_c),
    .color_i (dec_color_c),
    .leds_o  (leds_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= '0;
      on_last_q <= '0;
      tick_q    <= '0;
      color_q   <= RED;
      leds_q    <= '0;
      mem_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      leds_q   <= leds_c;
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort_c) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_ok_c) begin
              state_q   <= FETCH;
              last_q    <= bus.last_index;
              on_last_q <= bus.speed ? FAST_LAST : SLOW_LAST;
              mem_rd_q  <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          FETCH: state_q <= LOAD;
          LOAD: begin
            color_q <= color_t'(bus.mem_data);
            tick_q  <= on_last_q;
            state_q <= ON;
          end
          ON: begin
            if (tick_zero_c) begin
              tick_q  <= GAP_LAST;
              state_q <= OFF;
            end else begin
              tick_q <= tick_q - TICK_W'(1);
            end
          end
          OFF: begin
            if (!tick_zero_c) begin
              tick_q <= tick_q - TICK_W'(1);
            end else if (last_item_c) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= FETCH;
              mem_rd_q <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = addr_c;
  assign bus.led_red    = leds_q.red;
  assign bus.led_green  = leds_q.green;
  assign bus.led_blue   = leds_q.blue;
  assign bus.led_yellow = leds_q.yellow;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: table-driven playbacks, hand-written
// abort/reset corners and random playbacks against a cycle-timeline model.
module tb_sequence_player;

  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 2;
  localparam int unsigned FAST_ON = 4;
  localparam int unsigned SLOW_ON = 8;
  localparam int unsigned GAP     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequence_player_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sequence_player #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FAST_ON    (FAST_ON),
    .SLOW_ON    (SLOW_ON),
    .GAP        (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory with one-cycle read latency; garbage on the bus when not reading.
  logic [1:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) bus.mem_data <= mem[bus.mem_addr];
    else                     bus.mem_data <= 2'($urandom);
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          li;
    bit          spd;
    logic [63:0] mem_bits;
    bit          perturb;
    bit          start_busy;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, got, exp);
    end
  endtask

  // {addr(5), mem_rd, yellow, blue, green, red, busy, done}
  function automatic logic [11:0] observe(input logic addr_care);
    return {addr_care ? bus.mem_addr : 5'd0, bus.mem_rd, bus.led_yellow,
            bus.led_blue, bus.led_green, bus.led_red, bus.busy, bus.done};
  endfunction

  // Expected outputs in cycle t of a playback of n items (start accepted at edge 0).
  function automatic logic [11:0] model(input int t, input int n, input int onl);
    int len;
    int tot;
    int k;
    int ph;
    logic [11:0] e;
    len = 2 + onl + int'(GAP);
    tot = 1 + n * len;
    e   = '0;
    if (t >= 1 && t < tot) begin
      k    = (t - 1) / len;
      ph   = (t - 1) % len;
      e[1] = 1'b1;
      if (ph == 0) begin
        e[6]    = 1'b1;
        e[11:7] = 5'(k);
      end
      if (ph >= 2 && ph < 2 + onl) e[2 + int'(mem[k])] = 1'b1;
    end else if (t == tot) begin
      e[1] = 1'b1;
      e[0] = 1'b1;
    end
    return e;
  endfunction

  // Caller sits at a negedge; start is seen by the next rising edge (edge 0).
  task automatic run(input int li, input bit spd, input int abort_at,
                     input bit perturb, input bit start_busy, input int exp_done);
    int onl;
    int tot;
    int last_t;
    int done_at;
    logic [11:0] e;
    onl     = spd ? int'(FAST_ON) : int'(SLOW_ON);
    tot     = 1 + (li + 1) * (2 + onl + int'(GAP));
    last_t  = (abort_at > 0) ? abort_at + 4 : tot + 1;
    done_at = -1;
    bus.start      = 1'b1;
    bus.abort      = 1'b0;
    bus.last_index = 5'(li);
    bus.speed      = spd;
    @(negedge clk);
    for (int t = 1; t <= last_t; t++) begin
      e = (abort_at > 0 && t > abort_at) ? 12'h0 : model(t, li + 1, onl);
      if (bus.done === 1'b1 && done_at < 0) done_at = t;
      check("cycle", t, 32'(observe(e[6])), 32'(e));
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (perturb) begin
        bus.speed      = 1'($urandom);
        bus.last_index = 5'($urandom);
      end
      if (start_busy && (t == 3 || t == tot)) bus.start = 1'b1;
      if (t == abort_at) bus.abort = 1'b1;
      if (t < last_t) @(negedge clk);
    end
    check("done_cycle", last_t, 32'(done_at), 32'(exp_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int li;
    bit spd;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.last_index = '0;
    bus.speed      = 1'b0;
    rst            = 1'b1;
    for (int j = 0; j < 32; j++) mem[j] = 2'd0;
    repeat (2) @(negedge clk);
    check("reset", 0, 32'(observe(1'b1)), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{li: 2,  spd: 1'b1, mem_bits: 64'h1C,               perturb: 1'b0, start_busy: 1'b0, exp_done: 25};
    vecs[1] = '{li: 0,  spd: 1'b0, mem_bits: 64'h2,                perturb: 1'b0, start_busy: 1'b0, exp_done: 13};
    vecs[2] = '{li: 3,  spd: 1'b0, mem_bits: 64'hDEADBEEF01234567, perturb: 1'b1, start_busy: 1'b0, exp_done: 49};
    vecs[3] = '{li: 31, spd: 1'b1, mem_bits: 64'h5555555555555555, perturb: 1'b0, start_busy: 1'b0, exp_done: 257};
    vecs[4] = '{li: 4,  spd: 1'b1, mem_bits: 64'h00000000000002E4, perturb: 1'b0, start_busy: 1'b1, exp_done: 41};

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 32; j++) mem[j] = vecs[i].mem_bits[2*j +: 2];
      run(vecs[i].li, vecs[i].spd, -1, vecs[i].perturb, vecs[i].start_busy, vecs[i].exp_done);
    end

    // Abort in the middle of item 1's on-time (item 1 lit during cycles 11..14).
    for (int j = 0; j < 32; j++) mem[j] = 2'($urandom);
    run(2, 1'b1, 12, 1'b0, 1'b0, -1);

    // Abort and start together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_idle", 0, 32'(observe(1'b0)), 32'h0);
    @(negedge clk);
    check("abort_start_idle2", 1, 32'(observe(1'b0)), 32'h0);

    // Reset in the middle of item 1 (address counter at 1).
    bus.start      = 1'b1;
    bus.last_index = 5'd5;
    bus.speed      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_busy", 15, 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", 16, 32'(observe(1'b1)), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Random playbacks, each started immediately after the previous one ends.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 32; j++) mem[j] = 2'($urandom);
      li  = int'($urandom_range(0, 7));
      spd = 1'($urandom);
      run(li, spd, -1, 1'($urandom), 1'($urandom), 1 + (li + 1) * (2 + (spd ? int'(FAST_ON) : int'(SLOW_ON)) + int'(GAP)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
